// File: rtl/data_mem_ctrl.sv
// Load/store unit memory-port controller.
// Accepts one load/store from the pipeline, places it on a single-outstanding
// memory port with lane-aligned byte enables and data, extracts/extends load
// data, and returns a one-cycle completion (with error on misalign, illegal
// size or timeout).
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   req_*                    pipeline request (valid/ready, store, size,
//                            unsigned, addr, wdata, rd)
//   mem_*                    memory port (req/gnt, we, addr, be, wdata,
//                            rvalid/rdata)
//   rsp_*                    one-cycle completion (valid, rd, data, err)
//   stall_o                  hold pipeline while a request is outstanding
module data_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_store_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rsp_valid_o,
  output logic [4:0]  rsp_rd_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        stall_o
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_store;
  logic [1:0]         r_size;
  logic               r_unsigned;
  logic [1:0]         r_lane;
  logic [4:0]         r_rd;
  logic               r_ready;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [31:0]        r_mem_addr;
  logic [3:0]         r_mem_be;
  logic [31:0]        r_mem_wdata;
  logic               r_rsp_valid;
  logic               r_rsp_err;
  logic [4:0]         r_rsp_rd;
  logic [31:0]        r_rsp_data;

  logic               w_illegal;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [7:0]         w_lane_byte;
  logic [15:0]        w_lane_half;
  logic [31:0]        w_load_data;
  logic               w_timeout;

  // Request decode: alignment check, byte enables and lane replication
  always_comb begin
    w_illegal = 1'b0;
    w_be      = 4'b0000;
    w_wdata   = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        w_be    = 4'b0001 << req_addr_i[1:0];
        w_wdata = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        w_be      = 4'b0011 << req_addr_i[1:0];
        w_wdata   = {2{req_wdata_i[15:0]}};
        w_illegal = req_addr_i[0];
      end
      2'b10: begin
        w_be      = 4'b1111;
        w_illegal = |req_addr_i[1:0];
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Load lane select and sign/zero extension from the latched request
  always_comb begin
    w_lane_byte = mem_rdata_i[7:0];
    case (r_lane)
      2'd1:    w_lane_byte = mem_rdata_i[15:8];
      2'd2:    w_lane_byte = mem_rdata_i[23:16];
      2'd3:    w_lane_byte = mem_rdata_i[31:24];
      default: w_lane_byte = mem_rdata_i[7:0];
    endcase
    w_lane_half = r_lane[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (r_size)
      2'b00:   w_load_data = {{24{~r_unsigned & w_lane_byte[7]}}, w_lane_byte};
      2'b01:   w_load_data = {{16{~r_unsigned & w_lane_half[15]}}, w_lane_half};
      default: w_load_data = mem_rdata_i;
    endcase
  end

  // Last cycle of the allowed REQ+WAIT window
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Controller state, latched request and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_store     <= 1'b0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_lane      <= 2'b00;
      r_rd        <= '0;
      r_ready     <= 1'b1;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rd    <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_store    <= req_store_i;
            r_size     <= req_size_i;
            r_unsigned <= req_unsigned_i;
            r_lane     <= req_addr_i[1:0];
            r_rd       <= req_rd_i;
            if (w_illegal) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state     <= S_REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= req_store_i;
              r_mem_addr  <= {req_addr_i[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
            end
          end
        end
        S_REQ, S_WAIT: begin
          // Completion wins over a timeout landing in the same cycle
          if ((r_state == S_REQ && mem_gnt_i && mem_rvalid_i) ||
              (r_state == S_WAIT && mem_rvalid_i)) begin
            r_state     <= S_RESP;
            r_mem_req   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rd    <= r_store ? 5'd0 : r_rd;
            r_rsp_data  <= r_store ? 32'd0 : w_load_data;
          end else if (w_timeout) begin
            r_state     <= S_RESP;
            r_mem_req   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rd    <= '0;
            r_rsp_data  <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_state == S_REQ && mem_gnt_i) begin
              r_state   <= S_WAIT;
              r_mem_req <= 1'b0;
            end
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rd    <= '0;
          r_rsp_data  <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o = r_ready;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_be_o    = r_mem_be;
  assign mem_wdata_o = r_mem_wdata;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rd_o    = r_rsp_rd;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_err_o   = r_rsp_err;

  // Stall is combinational so the pipeline holds in the accepting cycle
  assign stall_o = (r_state == S_IDLE && req_valid_i) ||
                   (r_state == S_REQ) || (r_state == S_WAIT);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed vectors plus randomized
// loads/stores checked against a byte-level reference model.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        req_ready, mem_req, mem_we, rsp_valid, rsp_err, stall;
  logic [31:0] mem_addr, mem_wdata, rsp_data;
  logic [3:0]  mem_be;
  logic [4:0]  rsp_rd;

  logic        t_valid, t_gnt, t_rvalid;
  logic        t_ready, t_mem_req, t_mem_we, t_rsp_valid, t_rsp_err, t_stall;
  logic [31:0] t_mem_addr, t_mem_wdata, t_rsp_data;
  logic [3:0]  t_mem_be;
  logic [4:0]  t_rsp_rd;

  int n_checks;
  int n_fail;

  logic [3:0]  last_be;
  logic [31:0] last_addr, last_wdata, last_rsp_data;
  logic [4:0]  last_rsp_rd;
  logic        last_err, last_we;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_store_i(req_store),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_rd_i(req_rd),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .rsp_valid_o(rsp_valid), .rsp_rd_o(rsp_rd), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .stall_o(stall)
  );

  data_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(t_valid), .req_ready_o(t_ready), .req_store_i(req_store),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_rd_i(req_rd),
    .mem_req_o(t_mem_req), .mem_gnt_i(t_gnt), .mem_we_o(t_mem_we), .mem_addr_o(t_mem_addr),
    .mem_be_o(t_mem_be), .mem_wdata_o(t_mem_wdata), .mem_rvalid_i(t_rvalid), .mem_rdata_i(mem_rdata),
    .rsp_valid_o(t_rsp_valid), .rsp_rd_o(t_rsp_rd), .rsp_data_o(t_rsp_data), .rsp_err_o(t_rsp_err),
    .stall_o(t_stall)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic is_bad(input logic [1:0] sz, input logic [31:0] addr);
    return (sz == 2'b11) || ((addr % nbytes(sz)) != 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] addr);
    logic [3:0] be;
    int lane;
    be = 4'b0000;
    lane = int'(addr % 32'd4);
    for (int k = 0; k < nbytes(sz); k++) be[lane + k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(sz);
    for (int j = 0; j < 4; j++) r[8*j +: 8] = wd[8*(j % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] rdata);
    longint v;
    int n, lane;
    n = nbytes(sz);
    lane = int'(addr % 32'd4);
    v = 0;
    for (int k = 0; k < n; k++) v += longint'(rdata[8*(lane + k) +: 8]) << (8 * k);
    if (!uns && v >= (64'sd1 <<< (8 * n - 1))) v -= (64'sd1 <<< (8 * n));
    return 32'(v);
  endfunction

  // Scramble request inputs after acceptance; the DUT must have latched them
  task automatic scramble_req();
    req_store    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_rd       = 5'($urandom);
  endtask

  // One transaction; gd = cycles before grant, rvd = cycles from grant to rvalid
  task automatic do_txn(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input int gd, input int rvd, input logic [31:0] rdat);
    logic bad;
    bad = is_bad(sz, addr);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_rd = rd;
    #1;
    check("ready_idle", 32'(req_ready), 32'd1);
    check("stall_accept", 32'(stall), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble_req();
    if (bad) begin
      check("err_memreq", 32'(mem_req), 32'd0);
      check("err_valid", 32'(rsp_valid), 32'd1);
      check("err_flag", 32'(rsp_err), 32'd1);
      check("err_rd", 32'(rsp_rd), 32'd0);
      check("err_data", rsp_data, 32'd0);
      check("err_stall", 32'(stall), 32'd0);
      last_err = rsp_err;
    end else begin
      last_be = mem_be; last_addr = mem_addr; last_wdata = mem_wdata; last_we = mem_we;
      for (int c = 0; c <= gd; c++) begin
        check("req_memreq", 32'(mem_req), 32'd1);
        check("req_addr", mem_addr, {addr[31:2], 2'b00});
        check("req_be", 32'(mem_be), 32'(exp_be(sz, addr)));
        check("req_we", 32'(mem_we), 32'(st));
        if (st) check("req_wdata", mem_wdata, exp_wdata(sz, wd));
        check("req_stall", 32'(stall), 32'd1);
        check("req_ready", 32'(req_ready), 32'd0);
        check("req_nrsp", 32'(rsp_valid), 32'd0);
        mem_gnt    = (c == gd);
        mem_rvalid = (c == gd) && (rvd == 0);
        mem_rdata  = mem_rvalid ? rdat : $urandom;
        @(posedge clk); #1;
      end
      mem_gnt = 1'b0;
      for (int c = 1; c <= rvd; c++) begin
        check("wait_memreq", 32'(mem_req), 32'd0);
        check("wait_stall", 32'(stall), 32'd1);
        check("wait_nrsp", 32'(rsp_valid), 32'd0);
        mem_rvalid = (c == rvd);
        mem_rdata  = mem_rvalid ? rdat : $urandom;
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b0;
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_err", 32'(rsp_err), 32'd0);
      check("rsp_rd", 32'(rsp_rd), st ? 32'd0 : 32'(rd));
      check("rsp_data", rsp_data, st ? 32'd0 : exp_load(sz, uns, addr, rdat));
      check("rsp_stall", 32'(stall), 32'd0);
      check("rsp_memreq", 32'(mem_req), 32'd0);
      last_rsp_data = rsp_data; last_rsp_rd = rsp_rd; last_err = rsp_err;
    end
    @(posedge clk); #1;
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
  endtask

  // Idle cycles with stray rvalid pulses that must be ignored
  task automatic idle_gap(input int n);
    for (int c = 0; c < n; c++) begin
      mem_rvalid = 1'($urandom);
      mem_rdata  = $urandom;
      @(posedge clk); #1;
      check("idle_nrsp", 32'(rsp_valid), 32'd0);
      check("idle_ready", 32'(req_ready), 32'd1);
      check("idle_stall", 32'(stall), 32'd0);
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    logic        st, uns;
    logic [1:0]  sz;
    logic [31:0] addr;
    int          r;
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    t_valid = 1'b0; t_gnt = 1'b0; t_rvalid = 1'b0;
    last_be = '0; last_addr = '0; last_wdata = '0; last_rsp_data = '0;
    last_rsp_rd = '0; last_err = 1'b0; last_we = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_memreq", 32'(mem_req), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_t_ready", 32'(t_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Signed byte load, top lane, fastest handshake
    do_txn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 5'd3, 0, 0, 32'h8000_0000);
    check("lb_be", 32'(last_be), 32'h8);
    check("lb_addr", last_addr, 32'h0000_1000);
    check("lb_data", last_rsp_data, 32'hFFFF_FF80);
    check("lb_rd", 32'(last_rsp_rd), 32'd3);

    // Half store to upper lane with delayed grant and ack
    do_txn(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 5'd9, 3, 2, 32'h1234_5678);
    check("sh_we", 32'(last_we), 32'd1);
    check("sh_be", 32'(last_be), 32'hC);
    check("sh_wdata", last_wdata, 32'hBEEF_BEEF);
    check("sh_rd", 32'(last_rsp_rd), 32'd0);
    check("sh_err", 32'(last_err), 32'd0);

    // Misaligned and illegal-size requests
    do_txn(1'b0, 2'b10, 1'b0, 32'h0000_0001, 32'h0, 5'd4, 0, 0, 32'h0);
    check("lw_mis_err", 32'(last_err), 32'd1);
    do_txn(1'b0, 2'b01, 1'b1, 32'h0000_0003, 32'h0, 5'd5, 0, 0, 32'h0);
    check("lhu_mis_err", 32'(last_err), 32'd1);
    do_txn(1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 5'd6, 0, 0, 32'h0);
    check("size11_err", 32'(last_err), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      st   = 1'($urandom);
      uns  = 1'($urandom);
      r    = int'($urandom_range(0, 7));
      sz   = (r < 7) ? 2'(r % 3) : 2'b11;
      addr = $urandom;
      if ($urandom_range(0, 9) < 7) addr = addr - (addr % nbytes(sz));
      do_txn(st, sz, uns, addr, $urandom, 5'($urandom), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 3)), $urandom);
      idle_gap(int'($urandom_range(0, 2)));
    end

    // Timeout with grant never given, then a late rvalid
    req_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h100; req_rd = 5'd7;
    t_valid = 1'b1;
    @(posedge clk); #1;
    t_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("to_memreq", 32'(t_mem_req), 32'd1);
      check("to_nrsp", 32'(t_rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    check("to_drop", 32'(t_mem_req), 32'd0);
    check("to_valid", 32'(t_rsp_valid), 32'd1);
    check("to_err", 32'(t_rsp_err), 32'd1);
    check("to_rd", 32'(t_rsp_rd), 32'd0);
    check("to_stall", 32'(t_stall), 32'd0);
    t_rvalid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("to_late_nrsp", 32'(t_rsp_valid), 32'd0);
      check("to_late_ready", 32'(t_ready), 32'd1);
    end
    t_rvalid = 1'b0;

    // Reset while waiting for a response
    req_store = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'hCAFE_F00D; req_rd = 5'd2;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    check("wait_pre_rst", 32'(stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(req_ready), 32'd1);
    check("arst_memreq", 32'(mem_req), 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_addr", mem_addr, 32'd0);
    check("arst_wdata", mem_wdata, 32'd0);
    check("arst_be", 32'(mem_be), 32'd0);
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) begin
      @(posedge clk); #1;
      check("postrst_nrsp", 32'(rsp_valid), 32'd0);
      check("postrst_ready", 32'(req_ready), 32'd1);
    end
    mem_rvalid = 1'b0;
    do_txn(1'b0, 2'b00, 1'b1, 32'h0000_3001, 32'h0, 5'd11, 1, 1, 32'h0000_AB00);
    check("lbu_data", last_rsp_data, 32'h0000_00AB);
    check("lbu_rd", 32'(last_rsp_rd), 32'd11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the bench always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
